// File: rtl/ram_bist_if.sv
// ram_bist_if: bus between the RAM BIST engine and its single-port RAM.
// It carries the test request, the RAM command/data lines and the test result.
// The BIST engine takes the master modport. The RAM and test environment take the slave modport.
interface ram_bist_if #(
  parameter int AW = 4,
  parameter int DW = 4
);
  logic          start;
  logic          we;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [AW:0]   err_count;

  modport master (
    input  start, read_data,
    output we, address, write_data, busy, done, pass, fail_addr, err_count
  );

  modport slave (
    output start, read_data,
    input  we, address, write_data, busy, done, pass, fail_addr, err_count
  );
endinterface

// File: rtl/ram_bist.sv
// ram_bist: march-style BIST for a single-port synchronous RAM.
// The engine writes expected(a) = a ^ SEED to every address. It then reads back
// each address (RD), compares it one cycle later (CMP) and counts mismatches.
// Optional feature macro RAM_BIST_INVERT_PASS_EN adds a second pass that writes
// and checks ~(a ^ SEED). Error count and fail address accumulate over both passes.
// All outputs are registered. An asynchronous active-high rst aborts a running test.
module ram_bist #(
  parameter int            AW   = 4,
  parameter int            DW   = 4,
  parameter logic [DW-1:0] SEED = 4'hA
) (
  input  logic      clk,
  input  logic      rst,
  ram_bist_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
  localparam logic [AW:0]   ERR_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   ERR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   ERR_MAX   = {(AW+1){1'b1}};
  localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

  // Pattern for address a. When inv is set, the pattern is the inverse of the pass-0 pattern.
  function automatic logic [DW-1:0] expected_f(input logic [AW-1:0] a, input logic inv);
    logic [DW-1:0] v;
    v = a[DW-1:0] ^ SEED;
    return inv ? ~v : v;
  endfunction

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] address_q, address_d;
  logic [DW-1:0] write_data_q, write_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [AW:0]   err_count_q, err_count_d;

  logic          inv_s;
  logic          mismatch_s;
  logic [AW-1:0] addr_inc_s;
  logic [AW:0]   err_inc_s;

`ifdef RAM_BIST_INVERT_PASS_EN
  logic pass_idx_q, pass_idx_d;
  assign inv_s = pass_idx_q;
`else
  assign inv_s = 1'b0;
`endif

  assign addr_inc_s = address_q + ADDR_ONE;
  assign err_inc_s  = (err_count_q == ERR_MAX) ? err_count_q : (err_count_q + ERR_ONE);
  assign mismatch_s = (bus.read_data != expected_f(address_q, inv_s));

  // Next-state and next-output logic of the BIST sequencer.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    err_count_d  = err_count_q;
`ifdef RAM_BIST_INVERT_PASS_EN
    pass_idx_d   = pass_idx_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = WR;
          we_d         = 1'b1;
          address_d    = ADDR_ZERO;
          write_data_d = expected_f(ADDR_ZERO, 1'b0);
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          fail_addr_d  = ADDR_ZERO;
          err_count_d  = ERR_ZERO;
`ifdef RAM_BIST_INVERT_PASS_EN
          pass_idx_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      WR: begin
        if (address_q == ADDR_LAST) begin
          // The write phase ends here, so the address does not wrap back to 0 for another write.
          state_d      = RD;
          we_d         = 1'b0;
          address_d    = ADDR_ZERO;
          write_data_d = DATA_ZERO;
        end else begin
          address_d    = addr_inc_s;
          write_data_d = expected_f(addr_inc_s, inv_s);
        end
      end

      RD: begin
        state_d = CMP;
      end

      CMP: begin
        if (mismatch_s) begin
          err_count_d = err_inc_s;
          // The error count is still zero only before the first mismatch of this test.
          if (err_count_q == ERR_ZERO) begin
            fail_addr_d = address_q;
          end else begin
            fail_addr_d = fail_addr_q;
          end
        end else begin
          err_count_d = err_count_q;
        end

        if (address_q == ADDR_LAST) begin
`ifdef RAM_BIST_INVERT_PASS_EN
          if (!pass_idx_q) begin
            state_d      = WR;
            we_d         = 1'b1;
            address_d    = ADDR_ZERO;
            write_data_d = expected_f(ADDR_ZERO, 1'b1);
            pass_idx_d   = 1'b1;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == ERR_ZERO);
          end
`else
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == ERR_ZERO);
`endif
        end else begin
          state_d   = RD;
          address_d = addr_inc_s;
        end
      end

      DONE: begin
        // start is deliberately not looked at here; a new test begins only from IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d      = IDLE;
        we_d         = 1'b0;
        address_d    = ADDR_ZERO;
        write_data_d = DATA_ZERO;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and output registers. rst clears them at once, so we drops without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      address_q    <= ADDR_ZERO;
      write_data_q <= DATA_ZERO;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_addr_q  <= ADDR_ZERO;
      err_count_q  <= ERR_ZERO;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_addr_q  <= fail_addr_d;
      err_count_q  <= err_count_d;
    end
  end

`ifdef RAM_BIST_INVERT_PASS_EN
  // Pass index register. It exists only when the inverted second pass is built.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_idx_q <= 1'b0;
    end else begin
      pass_idx_q <= pass_idx_d;
    end
  end
`endif

  assign bus.we         = we_q;
  assign bus.address    = address_q;
  assign bus.write_data = write_data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_addr  = fail_addr_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 The module SHALL have parameter AW, default 4, meaning the address width.
REQ-002 The module SHALL have parameter DW, default 4, meaning the data width; AW = DW is required.
REQ-003 The module SHALL have parameter SEED, default 4'hA, meaning the pattern XOR seed.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit: a test request, sampled on the rising edge of clk.
REQ-007 The module SHALL have port we, output, 1 bit: the RAM write enable.
REQ-008 The module SHALL have port address, output, AW bits: the RAM address.
REQ-009 The module SHALL have port write_data, output, DW bits: the RAM write data.
REQ-010 The module SHALL have port read_data, input, DW bits: RAM read data, valid one cycle after address is presented with we=0.
REQ-011 The module SHALL have port busy, output, 1 bit: high while a test runs.
REQ-012 The module SHALL have port done, output, 1 bit: a one-cycle pulse at test end.
REQ-013 The module SHALL have port pass, output, 1 bit: the result of the last test, held until the next start.
REQ-014 The module SHALL have port fail_addr, output, AW bits: the first failing address, 0 if none.
REQ-015 The module SHALL have port err_count, output, AW+1 bits: the mismatch count, saturating at all-ones.

Function
REQ-016 The block SHALL act as initiator for the single-port RAM: it writes every address, then reads back and checks every address.
REQ-017 The block SHALL implement FSM states IDLE, WR, RD, CMP, DONE; all outputs SHALL be driven from registers.
REQ-018 IDLE -> WR SHALL occur when start=1; start SHALL be ignored in every state other than IDLE.
REQ-019 In WR the block SHALL hold we=1, with address stepping 0..2^AW-1 one per cycle and write_data = expected(address); after the last address it SHALL go to RD with address=0.
REQ-020 The expected value SHALL be expected(a) = a[DW-1:0] XOR SEED in pass 0.
REQ-021 In RD the block SHALL hold we=0 with address stable; the next state SHALL be CMP.
REQ-022 In CMP the block SHALL compare read_data against expected(address), then increment address and return to RD, or leave after the last address.
REQ-023 On a mismatch, err_count SHALL increment, saturating at 2^(AW+1)-1, and the first failing address SHALL be latched into fail_addr.
REQ-024 After the final CMP the FSM SHALL enter DONE for exactly 1 cycle with done=1, set pass = (err_count==0), then return to IDLE; busy SHALL be 0 in IDLE.
REQ-025 Latency with AW=4, macro off: done SHALL be high on the 49th cycle after start is sampled (16 WR + 32 RD/CMP + 1).
REQ-026 On start, err_count, fail_addr and pass SHALL clear in the same edge that leaves IDLE.
REQ-027 Address wrap from 2^AW-1 SHALL end the phase and SHALL NOT revisit address 0.
REQ-028 A start coincident with DONE SHALL be ignored; a new test SHALL start only from IDLE.

Reset
REQ-029 While rst=1, the block SHALL immediately and asynchronously be in state IDLE with we=0, address=0, write_data=0, busy=0, done=0, pass=0, fail_addr=0, err_count=0.
REQ-030 Reset mid-test SHALL abort with no result reported; we SHALL drop without waiting for a clock edge.

Configuration
REQ-031 The macro RAM_BIST_INVERT_PASS_EN SHALL control a second pass.
REQ-032 With RAM_BIST_INVERT_PASS_EN defined, after pass 0 the block SHALL run a second WR/RD/CMP pass with expected(a) = ~(a XOR SEED); counters and fail_addr SHALL accumulate across passes; done SHALL occur 97 cycles after start (AW=4).
REQ-033 Without RAM_BIST_INVERT_PASS_EN, only pass 0 SHALL exist and no pass-index register SHALL be synthesized.

Verification
REQ-034 Fault-free 16x4 RAM model, macro off, start pulse -> done on cycle 49, pass=1, err_count=0, fail_addr=0.
REQ-035 RAM model with read_data[0] stuck at 0 -> pass=0, fail_addr=1, err_count=8.
REQ-036 Start pulsed again at cycle 10 of a test -> ignored; a single done pulse on cycle 49.
REQ-037 rst asserted while address=5 in WR -> we=0, busy=0, address=0 before the next edge; a later start completes with pass=1.
REQ-038 Macro on, read_data[0] stuck at 0 -> done on cycle 97, err_count=16, fail_addr=1, pass=0.
REQ-039 Macro on, fault-free RAM -> pass=1; the write_data sequence in pass 1 begins 4'h5, 4'h4.
